// File: rtl/encoder4_2_seq.sv
// Registered 4-to-2 one-hot encoder with a valid/ready handshake and a one-entry output register.
// Illegal codes (all-zero or multi-hot) are flagged per word and counted in a saturating counter.
module encoder4_2_seq #(
  parameter int CNT_W         = 8,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic             out_multi,
  output logic             out_none,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg;
  logic             multi_reg, none_reg;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic       accept;
  logic [3:0] code_m;
  logic [2:0] ones;
  logic [1:0] enc_idx;
  logic       enc_multi, enc_none, illegal_acc;

  assign out_valid = (state_reg == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Masking with accept keeps an undriven in_code from reaching the decode logic.
  assign code_m = in_code & {4{accept}};

  always_comb begin
    ones    = 3'd0;
    enc_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ones = ones + {2'b00, code_m[i]};
    end
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 4; i++) begin
        if (code_m[i]) enc_idx = i[1:0];
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (code_m[i]) enc_idx = i[1:0];
      end
    end
    enc_none  = (ones == 3'd0);
    enc_multi = (ones > 3'd1);
  end

  assign illegal_acc = accept && (enc_none || enc_multi);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready) state_next = accept ? FULL : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // A clear in the same cycle as an illegal accept keeps that event.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr) begin
      err_cnt_next = illegal_acc ? CNT_W'(1) : '0;
    end else if (illegal_acc && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_next = err_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      idx_reg     <= 2'd0;
      multi_reg   <= 1'b0;
      none_reg    <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      err_cnt_reg <= err_cnt_next;
      if (accept) begin
        idx_reg   <= enc_idx;
        multi_reg <= enc_multi;
        none_reg  <= enc_none;
      end
    end
  end

  assign out_idx   = idx_reg;
  assign out_multi = multi_reg;
  assign out_none  = none_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Directed bench for encoder4_2_seq: three parameterisations share one stimulus stream.
// hi = defaults, lo = PRIORITY_HIGH 0, c2 = CNT_W 2.
module tb_encoder4_2_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, err_clr;
  logic [3:0] in_code;

  logic       hi_in_ready, hi_out_valid, hi_out_multi, hi_out_none;
  logic [1:0] hi_out_idx;
  logic [7:0] hi_err_cnt;
  logic       lo_in_ready, lo_out_valid, lo_out_multi, lo_out_none;
  logic [1:0] lo_out_idx;
  logic [7:0] lo_err_cnt;
  logic       c2_in_ready, c2_out_valid, c2_out_multi, c2_out_none;
  logic [1:0] c2_out_idx;
  logic [1:0] c2_err_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  encoder4_2_seq #(.CNT_W(8), .PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hi_in_ready), .in_code(in_code),
    .out_valid(hi_out_valid), .out_ready(out_ready), .out_idx(hi_out_idx),
    .out_multi(hi_out_multi), .out_none(hi_out_none), .err_clr(err_clr), .err_cnt(hi_err_cnt));

  encoder4_2_seq #(.CNT_W(8), .PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lo_in_ready), .in_code(in_code),
    .out_valid(lo_out_valid), .out_ready(out_ready), .out_idx(lo_out_idx),
    .out_multi(lo_out_multi), .out_none(lo_out_none), .err_clr(err_clr), .err_cnt(lo_err_cnt));

  encoder4_2_seq #(.CNT_W(2), .PRIORITY_HIGH(1'b1)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready), .in_code(in_code),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_idx(c2_out_idx),
    .out_multi(c2_out_multi), .out_none(c2_out_none), .err_clr(err_clr), .err_cnt(c2_err_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-20s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] codes [4];
    logic [3:0] bad [5];
    logic [1:0] c2_exp [5];
    codes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bad   = '{4'b0000, 4'b1111, 4'b0101, 4'b0000, 4'b1010};
    c2_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held 2 clks with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_code = 4'b0001; out_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", hi_out_valid, 1'b0);
    chk("rst_err_cnt", hi_err_cnt, 8'd0);
    chk("rst_out_idx", hi_out_idx, 2'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", hi_in_ready, 1'b1);

    // Back-to-back sweep, full throughput
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = codes[i];
      tick();
      chk("sweep_valid", hi_out_valid, 1'b1);
      chk("sweep_idx", hi_out_idx, i[1:0]);
      chk("sweep_flags", {hi_out_multi, hi_out_none}, 2'b00);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drained", hi_out_valid, 1'b0);
    chk("sweep_err_cnt", hi_err_cnt, 8'd0);

    // Illegal codes
    in_valid = 1'b1; in_code = 4'b0110;
    tick();
    chk("multi_hi_idx", hi_out_idx, 2'd2);
    chk("multi_hi_flags", {hi_out_multi, hi_out_none}, 2'b10);
    chk("multi_lo_idx", lo_out_idx, 2'd1);
    chk("multi_lo_flags", {lo_out_multi, lo_out_none}, 2'b10);
    in_code = 4'b0000;
    tick();
    chk("none_idx", hi_out_idx, 2'd0);
    chk("none_flags", {hi_out_multi, hi_out_none}, 2'b01);
    chk("illegal_err_cnt", hi_err_cnt, 8'd2);
    chk("illegal_lo_err_cnt", lo_err_cnt, 8'd2);
    in_valid = 1'b0;
    tick();

    // Backpressure: 2 held while 3 waits at the input
    in_valid = 1'b1; in_code = 4'b0100;
    tick();
    chk("bp_first_idx", hi_out_idx, 2'd2);
    out_ready = 1'b0; in_code = 4'b1000;
    #1;
    chk("bp_in_ready", hi_in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", hi_out_valid, 1'b1);
      chk("bp_hold_idx", hi_out_idx, 2'd2);
      chk("bp_hold_ready", hi_in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", hi_in_ready, 1'b1);
    tick();
    chk("bp_next_valid", hi_out_valid, 1'b1);
    chk("bp_next_idx", hi_out_idx, 2'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", hi_out_valid, 1'b0);
    chk("bp_err_cnt", hi_err_cnt, 8'd2);

    // Undriven in_code without in_valid is ignored
    in_code = 4'bxxxx;
    tick();
    chk("x_out_valid", hi_out_valid, 1'b0);
    chk("x_out_idx", hi_out_idx, 2'd3);
    chk("x_err_cnt", hi_err_cnt, 8'd2);

    // Clear, then saturation on the 2-bit counter
    err_clr = 1'b1;
    tick();
    chk("clr_hi", hi_err_cnt, 8'd0);
    chk("clr_c2", c2_err_cnt, 2'd0);
    tick();
    chk("clr_at_zero", c2_err_cnt, 2'd0);
    err_clr = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code = bad[i];
      tick();
      chk("sat_c2", c2_err_cnt, c2_exp[i]);
      chk("sat_hi", hi_err_cnt, 8'(i + 1));
    end
    err_clr = 1'b1; in_code = 4'b1100;
    tick();
    chk("clr_with_illegal_c2", c2_err_cnt, 2'd1);
    chk("clr_with_illegal_hi", hi_err_cnt, 8'd1);
    chk("clr_hi_idx", hi_out_idx, 2'd3);
    chk("clr_lo_idx", lo_out_idx, 2'd2);
    err_clr = 1'b0; in_valid = 1'b0;
    tick();

    // Reset while a word is held
    in_valid = 1'b1; in_code = 4'b0011;
    tick();
    chk("mid_pre_valid", hi_out_valid, 1'b1);
    chk("mid_pre_idx", hi_out_idx, 2'd1);
    chk("mid_pre_err", hi_err_cnt, 8'd2);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("mid_valid", hi_out_valid, 1'b0);
    chk("mid_err_cnt", hi_err_cnt, 8'd0);
    chk("mid_idx", hi_out_idx, 2'd0);
    chk("mid_flags", {hi_out_multi, hi_out_none}, 2'b00);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("mid_never_delivered", hi_out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
